// File: rtl/fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_arbiter
//
// Shares one external float32 multiplier between NUM_REQ requesters.
// The multiplier has one product register behind MUL_REG_EN. Its NaN/Inf/zero
// override is combinational on MUL_A/MUL_B.
//
// Each operation takes three states:
//   IDLE    -> grant a requester and latch its operands and index
//   ISSUE   -> pulse MUL_REG_EN so the multiplier captures the product
//   CAPTURE -> hold the operands and load MUL_OUT into the result register
//
// A CAPTURE that completes can grant the next requester in the same cycle.
// This gives one operation every two cycles. Results leave in grant order.
//
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   REQ_VALID/REQ_READY   per-requester handshake (REQ_READY one-hot or zero)
//   REQ_A/REQ_B           packed operands, requester i at [32i+31:32i]
//   MUL_A/MUL_B           operands to the multiplier (registered)
//   MUL_REG_EN            multiplier product register enable (registered)
//   MUL_OUT               multiplier result
//   RES_VALID/RES_READY   result handshake
//   RES_DATA/RES_ID       product and index of the issuing requester
//
// Build option:
//   FP_MUL_ARB_FIXED_PRIO_EN  fixed priority, lowest index wins. The default
//                             build uses round-robin.
// -----------------------------------------------------------------------------
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    output logic [NUM_REQ-1:0]    REQ_READY,
    input  logic [32*NUM_REQ-1:0] REQ_A,
    input  logic [32*NUM_REQ-1:0] REQ_B,
    output logic [31:0]           MUL_A,
    output logic [31:0]           MUL_B,
    output logic                  MUL_REG_EN,
    input  logic [31:0]           MUL_OUT,
    output logic                  RES_VALID,
    input  logic                  RES_READY,
    output logic [31:0]           RES_DATA,
    output logic [ID_W-1:0]       RES_ID
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [31:0]     op_a_r;
    logic [31:0]     op_b_r;
    logic [ID_W-1:0] tag_r;
    logic            mul_reg_en_r;
    logic            res_valid_r;
    logic [31:0]     res_data_r;
    logic [ID_W-1:0] res_id_r;

    logic            any_valid_s;
    logic            complete_s;
    logic            grant_en_s;
    logic [ID_W-1:0] grant_idx_s;
    logic [31:0]     sel_a_s;
    logic [31:0]     sel_b_s;

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest valid index is written last.
    always_comb begin
        grant_idx_s = {ID_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            grant_idx_s = REQ_VALID[i] ? ID_W'(i) : grant_idx_s;
        end
    end
`else
    logic [ID_W-1:0] last_grant_r;
    logic [ID_W-1:0] hi_idx_s;
    logic [ID_W-1:0] lo_idx_s;
    logic            hi_found_s;

    // Round-robin search from last_grant+1.
    // A valid requester above the pointer wins. Otherwise the scan wraps to
    // the lowest valid index.
    always_comb begin
        hi_idx_s   = {ID_W{1'b0}};
        lo_idx_s   = {ID_W{1'b0}};
        hi_found_s = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            lo_idx_s   = REQ_VALID[i] ? ID_W'(i) : lo_idx_s;
            hi_idx_s   = (REQ_VALID[i] && (i > int'(last_grant_r))) ? ID_W'(i) : hi_idx_s;
            hi_found_s = hi_found_s | (REQ_VALID[i] && (i > int'(last_grant_r)));
        end
        if (hi_found_s) begin
            grant_idx_s = hi_idx_s;
        end else begin
            grant_idx_s = lo_idx_s;
        end
    end

    // Round-robin pointer. The reset value makes requester 0 the first choice.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_r <= ID_W'(NUM_REQ - 1);
        end else if (grant_en_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Grant slot: IDLE, or a CAPTURE whose result can be stored this cycle.
    always_comb begin
        any_valid_s = |REQ_VALID;
        complete_s  = (state_r == ST_CAPTURE) && (!res_valid_r || RES_READY);
        grant_en_s  = any_valid_s && ((state_r == ST_IDLE) || complete_s);
    end

    // Operand mux for the granted requester, plus the one-hot grant strobe.
    always_comb begin
        sel_a_s   = 32'd0;
        sel_b_s   = 32'd0;
        REQ_READY = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s      = (grant_idx_s == ID_W'(i)) ? REQ_A[32*i +: 32] : sel_a_s;
            sel_b_s      = (grant_idx_s == ID_W'(i)) ? REQ_B[32*i +: 32] : sel_b_s;
            REQ_READY[i] = grant_en_s && (grant_idx_s == ID_W'(i));
        end
    end

    // Next-state logic for the issue/capture sequencer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!complete_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else if (any_valid_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, operand, tag and result registers.
    // Operands change only on a grant. They stay stable through CAPTURE, and
    // through a stall, so the multiplier's combinational override stays valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            tag_r        <= {ID_W{1'b0}};
            mul_reg_en_r <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= 32'd0;
            res_id_r     <= {ID_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            // A grant always leads to ISSUE, the only cycle that enables the
            // product register.
            mul_reg_en_r <= grant_en_s;
            if (grant_en_s) begin
                op_a_r <= sel_a_s;
                op_b_r <= sel_b_s;
                tag_r  <= grant_idx_s;
            end else begin
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
                tag_r  <= tag_r;
            end
            // A completing capture overrides a consumer pop in the same cycle.
            if (complete_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= MUL_OUT;
                res_id_r    <= tag_r;
            end else if (res_valid_r && RES_READY) begin
                res_valid_r <= 1'b0;
                res_data_r  <= res_data_r;
                res_id_r    <= res_id_r;
            end else begin
                res_valid_r <= res_valid_r;
                res_data_r  <= res_data_r;
                res_id_r    <= res_id_r;
            end
        end
    end

    assign MUL_A      = op_a_r;
    assign MUL_B      = op_b_r;
    assign MUL_REG_EN = mul_reg_en_r;
    assign RES_VALID  = res_valid_r;
    assign RES_DATA   = res_data_r;
    assign RES_ID     = res_id_r;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fp_mul_arbiter.
// A behavioural float32 multiplier stands in for the shared unit. Its product
// is registered on MUL_REG_EN. NaN/Inf/zero results are computed directly from
// the current MUL_A/MUL_B.
// Directed vectors come from a table, followed by hand-written multi-cycle
// sequences and a randomized run against a grant-order scoreboard.
// -----------------------------------------------------------------------------
module tb_fp_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    REQ_READY;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [31:0]           MUL_A;
    logic [31:0]           MUL_B;
    logic                  MUL_REG_EN;
    logic [31:0]           mul_out;
    logic                  RES_VALID;
    logic                  res_ready;
    logic [31:0]           RES_DATA;
    logic [ID_W-1:0]       RES_ID;

    logic [31:0] op_a [NUM_REQ];
    logic [31:0] op_b [NUM_REQ];
    logic [31:0] prod_q;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          id;
    } res_t;

    vec_t               vecs [6];
    res_t               sb_q [$];
    int                 last_grant_m;
    logic [NUM_REQ-1:0] prev_ready;
    logic [NUM_REQ-1:0] granted_m;
    int                 n_grants;
    int                 n_pass  = 0;
    int                 n_total = 0;
    int                 g_idx [$];
    int                 g_cyc [$];
    int                 r_id [$];
    logic [31:0]        r_data [$];
    int                 exp_g [5];
    logic [31:0]        exp_d [NUM_REQ];

    always #5 CLK = ~CLK;

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (req_valid),
        .REQ_READY  (REQ_READY),
        .REQ_A      (req_a),
        .REQ_B      (req_b),
        .MUL_A      (MUL_A),
        .MUL_B      (MUL_B),
        .MUL_REG_EN (MUL_REG_EN),
        .MUL_OUT    (mul_out),
        .RES_VALID  (RES_VALID),
        .RES_READY  (res_ready),
        .RES_DATA   (RES_DATA),
        .RES_ID     (RES_ID)
    );

    // Reference float32 multiply: denormals flushed, mantissa truncated.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        int e;
        logic [47:0] p;
        logic [22:0] frac;
        logic [31:0] r;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        r = 32'd0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            r = 32'h7FC00000;
        end else if (a_inf || b_inf) begin
            r = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            r = {s, 31'd0};
        end else begin
            p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            if (p[47]) begin
                frac = p[46:24];
                e    = e + 1;
            end else begin
                frac = p[45:23];
            end
            if (e >= 255)    r = {s, 8'hFF, 23'd0};
            else if (e <= 0) r = {s, 31'd0};
            else             r = {s, e[7:0], frac};
        end
        return r;
    endfunction

    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (a[30:23] == 8'd0) ||
               (b[30:23] == 8'hFF) || (b[30:23] == 8'd0);
    endfunction

    function automatic logic [31:0] rand_f32();
        int k;
        logic [31:0] r;
        k = int'($urandom_range(0, 11));
        case (k)
            0:       r = 32'h00000000;
            1:       r = 32'h7F800000;
            2:       r = 32'h7FC00000;
            default: r = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        endcase
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (v[k]) r = k;
        end
        return r;
    endfunction

    // Multiplier stand-in: product register behind MUL_REG_EN.
    always_ff @(posedge CLK) begin
        if (MUL_REG_EN) prod_q <= fmul(MUL_A, MUL_B);
    end

    // Special-case results come straight from the current MUL_A/MUL_B.
    always_comb begin
        mul_out = is_special(MUL_A, MUL_B) ? fmul(MUL_A, MUL_B) : prod_q;
    end

    // Pack per-requester operands onto the wide buses.
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[32*i +: 32] = op_a[i];
            req_b[32*i +: 32] = op_b[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = 32'd0;
            op_b[i] = 32'd0;
        end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // One isolated operation. Checks grant, issue, capture and result timing.
    task automatic run_single(input vec_t v);
        @(posedge CLK); #1;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        op_a[v.id] = v.a;
        op_b[v.id] = v.b;
        @(negedge CLK);
        chk("grant_pulse", 32'(REQ_READY), 32'(req_valid));
        @(posedge CLK); #1;
        req_valid = '0;
        @(negedge CLK);
        chk("issue_en", 32'(MUL_REG_EN), 32'd1);
        chk("issue_no_ready", 32'(REQ_READY), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("capture_en", 32'(MUL_REG_EN), 32'd0);
        chk("capture_a", MUL_A, v.a);
        chk("capture_b", MUL_B, v.b);
        chk("capture_no_res", 32'(RES_VALID), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("res_valid", 32'(RES_VALID), 32'd1);
        chk("res_data", RES_DATA, v.exp);
        chk("res_id", 32'(RES_ID), 32'(v.id));
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("res_popped", 32'(RES_VALID), 32'd0);
    endtask

    // Per-cycle scoreboard. Checks the arbitration choice and grant spacing,
    // and that results come back in grant order.
    task automatic monitor();
        int idx;
        int exp_idx;
        int j;
        res_t e;
        if (REQ_READY != '0) begin
            idx = onehot_idx(REQ_READY);
            chk("ready_onehot", 32'($countones(REQ_READY)), 32'd1);
            chk("ready_gap", 32'(prev_ready != '0), 32'd0);
            exp_idx = -1;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[k]) exp_idx = k;
            end
`else
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (last_grant_m + k) % NUM_REQ;
                if (exp_idx < 0 && req_valid[j]) exp_idx = j;
            end
`endif
            chk("arb_grant", 32'(idx), 32'(exp_idx));
            sb_q.push_back('{data: fmul(op_a[idx], op_b[idx]), id: idx});
            last_grant_m   = idx;
            granted_m[idx] = 1'b1;
            n_grants++;
        end
        prev_ready = REQ_READY;
        if (RES_VALID && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("res_unexpected", 32'(RES_VALID), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", RES_DATA, e.data);
                chk("sb_id", 32'(RES_ID), 32'(e.id));
            end
        end
    endtask

    initial begin
        vecs[0] = '{id: 0, a: 32'h3FC00000, b: 32'h3FC00000, exp: 32'h40100000};
        vecs[1] = '{id: 1, a: 32'hC0000000, b: 32'h40400000, exp: 32'hC0C00000};
        vecs[2] = '{id: 2, a: 32'h7F800000, b: 32'h40000000, exp: 32'h7F800000};
        vecs[3] = '{id: 3, a: 32'h7FC00001, b: 32'h3F800000, exp: 32'h7FC00000};
        vecs[4] = '{id: 2, a: 32'h00000000, b: 32'h40000000, exp: 32'h00000000};
        vecs[5] = '{id: 1, a: 32'h40400000, b: 32'h40400000, exp: 32'h41100000};

        // Reset state.
        do_reset();
        @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_mul_en", 32'(MUL_REG_EN), 32'd0);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_res_data", RES_DATA, 32'd0);
        chk("rst_res_id", 32'(RES_ID), 32'd0);
        chk("rst_mul_a", MUL_A, 32'd0);
        chk("rst_mul_b", MUL_B, 32'd0);

        // Table-driven single operations.
        for (int v = 0; v < 6; v++) run_single(vecs[v]);

        // Requesters held valid continuously, consumer always ready.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = vecs[i].a;
            op_b[i] = vecs[i].b;
            exp_d[i] = vecs[i].exp;
        end
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
            if (c == 0) req_valid = 4'b1001;
`else
            if (c == 0) req_valid = 4'b1111;
`endif
            @(negedge CLK);
            if (REQ_READY != '0) begin
                g_idx.push_back(onehot_idx(REQ_READY));
                g_cyc.push_back(c);
            end
            if (RES_VALID) begin
                r_id.push_back(int'(RES_ID));
                r_data.push_back(RES_DATA);
            end
        end
        chk("stream_ngrant", 32'(g_idx.size() >= 5), 32'd1);
        chk("stream_nres", 32'(r_id.size() >= 4), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < g_idx.size()) begin
                chk("stream_grant", 32'(g_idx[k]), 32'(exp_g[k]));
                chk("stream_spacing", 32'(g_cyc[k]), 32'(2 * k));
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (k < r_id.size()) begin
                chk("stream_res_id", 32'(r_id[k]), 32'(exp_g[k]));
                chk("stream_res_data", r_data[k], exp_d[exp_g[k]]);
            end
        end

        // Backpressure: second op stalls in CAPTURE behind an unread result.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            case (c)
                0: begin
                    res_ready = 1'b0;
                    req_valid = 4'b0001;
                    op_a[0] = 32'h3FC00000;
                    op_b[0] = 32'h3FC00000;
                end
                1: begin
                    req_valid = 4'b0010;
                    op_a[1] = 32'hC0000000;
                    op_b[1] = 32'h40400000;
                end
                3: req_valid = 4'b0000;
                9: res_ready = 1'b1;
                default: ;
            endcase
            @(negedge CLK);
            if (c == 0) chk("bp_grant0", 32'(REQ_READY), 32'd1);
            if (c == 1) chk("bp_no_grant_issue", 32'(REQ_READY), 32'd0);
            if (c == 2) chk("bp_grant1", 32'(REQ_READY), 32'd2);
            if (c >= 4 && c <= 8) begin
                chk("bp_hold_a", MUL_A, 32'hC0000000);
                chk("bp_hold_b", MUL_B, 32'h40400000);
                chk("bp_hold_en", 32'(MUL_REG_EN), 32'd0);
                chk("bp_hold_ready", 32'(REQ_READY), 32'd0);
            end
            if (c >= 3 && c <= 9) begin
                chk("bp_first_valid", 32'(RES_VALID), 32'd1);
                chk("bp_first_data", RES_DATA, 32'h40100000);
                chk("bp_first_id", 32'(RES_ID), 32'd0);
            end
            if (c == 10) begin
                chk("bp_second_valid", 32'(RES_VALID), 32'd1);
                chk("bp_second_data", RES_DATA, 32'hC0C00000);
                chk("bp_second_id", 32'(RES_ID), 32'd1);
            end
            if (c == 11) chk("bp_no_dup", 32'(RES_VALID), 32'd0);
        end

        // Reset during ISSUE drops the op and restarts priority at index 0.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            case (c)
                0: begin
                    req_valid = 4'b0100;
                    op_a[2] = 32'h3F800000;
                    op_b[2] = 32'h40000000;
                end
                1: begin
                    req_valid = 4'b0000;
                    RST = 1'b1;
                end
                2: begin
                    RST = 1'b0;
                    req_valid = 4'b1010;
                    op_a[1] = 32'h3FC00000;
                    op_b[1] = 32'h3FC00000;
                    op_a[3] = 32'h40400000;
                    op_b[3] = 32'h40400000;
                end
                3: req_valid = 4'b1000;
                5: req_valid = 4'b0000;
                default: ;
            endcase
            @(negedge CLK);
            if (c == 0) chk("rr_pre_grant", 32'(REQ_READY), 32'd4);
            if (c == 1) chk("rr_in_issue", 32'(MUL_REG_EN), 32'd1);
            if (c == 2) begin
                chk("rr_post_en", 32'(MUL_REG_EN), 32'd0);
                chk("rr_post_valid", 32'(RES_VALID), 32'd0);
                chk("rr_post_mul_a", MUL_A, 32'd0);
                chk("rr_post_grant", 32'(REQ_READY), 32'd2);
            end
            if (c == 3) chk("rr_post_no_res", 32'(RES_VALID), 32'd0);
            if (c == 4) chk("rr_next_grant", 32'(REQ_READY), 32'd8);
            if (c == 5) begin
                chk("rr_res1_valid", 32'(RES_VALID), 32'd1);
                chk("rr_res1_id", 32'(RES_ID), 32'd1);
                chk("rr_res1_data", RES_DATA, 32'h40100000);
            end
            if (c == 6) chk("rr_res_gap", 32'(RES_VALID), 32'd0);
            if (c == 7) begin
                chk("rr_res2_id", 32'(RES_ID), 32'd3);
                chk("rr_res2_data", RES_DATA, 32'h41100000);
            end
        end

        // Randomized traffic against the scoreboard.
        do_reset();
        last_grant_m = NUM_REQ - 1;
        sb_q.delete();
        prev_ready = '0;
        granted_m  = '0;
        n_grants   = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge CLK); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (granted_m[i]) begin
                    granted_m[i] = 1'b0;
                    req_valid[i] = 1'($urandom_range(0, 1));
                    op_a[i] = rand_f32();
                    op_b[i] = rand_f32();
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    op_a[i] = rand_f32();
                    op_b[i] = rand_f32();
                end
            end
            res_ready = ($urandom_range(0, 9) < 7);
            @(negedge CLK);
            monitor();
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            req_valid = '0;
            res_ready = 1'b1;
            @(negedge CLK);
            monitor();
        end
        chk("rand_drained", 32'(sb_q.size()), 32'd0);
        chk("rand_activity", 32'(n_grants > 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
